bp_xui_mem_responder: RTL and testbench

- Memory-controller side of the Xilinx MIG user interface (app_*); the responder end of the BlackParrot CCE-to-XUI adapter.
- Accepts UI read and write commands and a decoupled write-data channel, and stores data in an internal banked memory.
- Returns read data in order after a fixed latency.
- Used as a simulation and FPGA bring-up stand-in for the DDR4 MIG, so the adapter can be exercised without a physical DRAM.

---
 rtl/bp_xui_mem_responder.sv | 184 ++++++++++++++++++
 tb/tb_bp_xui_mem_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bp_xui_mem_responder.sv
// MIG user-interface responder: queues app_* commands and write data, executes them
// in order against a banked backing store, and returns read data after a fixed latency.
module bp_xui_mem_responder #(
  parameter int unsigned addr_width_p   = 28,
  parameter int unsigned data_width_p   = 512,
  parameter int unsigned mem_els_p      = 64,
  parameter int unsigned cmd_fifo_els_p = 4,
  parameter int unsigned wdf_fifo_els_p = 4,
  parameter int unsigned read_latency_p = 4,
  parameter int unsigned calib_cycles_p = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [addr_width_p-1:0]   app_addr_i,
  input  logic [2:0]                app_cmd_i,
  input  logic                      app_en_i,
  output logic                      app_rdy_o,
  input  logic                      app_wdf_wren_i,
  input  logic [data_width_p-1:0]   app_wdf_data_i,
  input  logic [data_width_p/8-1:0] app_wdf_mask_i,
  input  logic                      app_wdf_end_i,
  output logic                      app_wdf_rdy_o,
  output logic                      app_rd_data_valid_o,
  output logic [data_width_p-1:0]   app_rd_data_o,
  output logic                      app_rd_data_end_o,
  output logic                      init_calib_complete_o,
  output logic                      error_o
);

  localparam int unsigned byte_lp   = data_width_p / 8;
  localparam int unsigned off_lp    = $clog2(byte_lp);
  localparam int unsigned idx_w_lp  = $clog2(mem_els_p);
  localparam int unsigned cptr_w_lp = $clog2(cmd_fifo_els_p);
  localparam int unsigned ccnt_w_lp = cptr_w_lp + 1;
  localparam int unsigned wptr_w_lp = $clog2(wdf_fifo_els_p);
  localparam int unsigned wcnt_w_lp = wptr_w_lp + 1;
  localparam int unsigned cal_w_lp  = $clog2(calib_cycles_p) + 1;

  localparam logic [2:0] cmd_write_lp = 3'b000;
  localparam logic [2:0] cmd_read_lp  = 3'b001;

  logic [data_width_p-1:0] mem_r [mem_els_p];

  logic [2:0]              cmd_q_r  [cmd_fifo_els_p];
  logic [idx_w_lp-1:0]     idx_q_r  [cmd_fifo_els_p];
  logic [cptr_w_lp-1:0]    cmd_wptr_r, cmd_rptr_r;
  logic [ccnt_w_lp-1:0]    cmd_cnt_r, cmd_cnt_n;

  logic [data_width_p-1:0] wdf_data_q_r [wdf_fifo_els_p];
  logic [byte_lp-1:0]      wdf_mask_q_r [wdf_fifo_els_p];
  logic [wptr_w_lp-1:0]    wdf_wptr_r, wdf_rptr_r;
  logic [wcnt_w_lp-1:0]    wdf_cnt_r, wdf_cnt_n;

  logic [cal_w_lp-1:0]     cal_cnt_r;
  logic                    calib_r, calib_n;
  logic                    error_r, error_n;

  logic [read_latency_p-1:0] rv_r;
  logic [data_width_p-1:0]   rd_r [read_latency_p];

  logic                    cmd_push, wdf_push;
  logic                    cmd_pop, wdf_pop, rd_fire, bad_cmd;
  logic [2:0]              head_cmd;
  logic [idx_w_lp-1:0]     head_idx;
  logic [idx_w_lp-1:0]     app_idx;
  logic [data_width_p-1:0] rd_word;
  logic [addr_width_p-1:0] addr_unused;

  // Only the word-index slice of the byte address matters; the rest wraps away.
  assign app_idx     = app_addr_i[off_lp +: idx_w_lp];
  assign addr_unused = app_addr_i;

  assign cmd_push = app_en_i & app_rdy_o;
  assign wdf_push = app_wdf_wren_i & app_wdf_rdy_o;
  assign head_cmd = cmd_q_r[cmd_rptr_r];
  assign head_idx = idx_q_r[cmd_rptr_r];
  assign rd_word  = mem_r[head_idx];

  // In-order execute stage: one head command per cycle.
  always_comb begin
    cmd_pop = 1'b0;
    wdf_pop = 1'b0;
    rd_fire = 1'b0;
    bad_cmd = 1'b0;
    if (cmd_cnt_r != '0) begin
      case (head_cmd)
        cmd_write_lp: begin
          if (wdf_cnt_r != '0) begin
            cmd_pop = 1'b1;
            wdf_pop = 1'b1;
          end
        end
        cmd_read_lp: begin
          cmd_pop = 1'b1;
          rd_fire = 1'b1;
        end
        default: begin
          cmd_pop = 1'b1;
          bad_cmd = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    cmd_cnt_n = cmd_cnt_r + ccnt_w_lp'(cmd_push) - ccnt_w_lp'(cmd_pop);
    wdf_cnt_n = wdf_cnt_r + wcnt_w_lp'(wdf_push) - wcnt_w_lp'(wdf_pop);
    calib_n   = calib_r | (cal_cnt_r == cal_w_lp'(calib_cycles_p - 1));
    error_n   = error_r | bad_cmd | (app_wdf_wren_i & ~app_wdf_end_i & app_wdf_rdy_o);
  end

  // Control state; readiness is registered from next-cycle occupancy.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cmd_wptr_r    <= '0;
      cmd_rptr_r    <= '0;
      cmd_cnt_r     <= '0;
      wdf_wptr_r    <= '0;
      wdf_rptr_r    <= '0;
      wdf_cnt_r     <= '0;
      cal_cnt_r     <= '0;
      calib_r       <= 1'b0;
      error_r       <= 1'b0;
      app_rdy_o     <= 1'b0;
      app_wdf_rdy_o <= 1'b0;
    end else begin
      if (cmd_push) cmd_wptr_r <= cmd_wptr_r + cptr_w_lp'(1);
      if (cmd_pop)  cmd_rptr_r <= cmd_rptr_r + cptr_w_lp'(1);
      if (wdf_push) wdf_wptr_r <= wdf_wptr_r + wptr_w_lp'(1);
      if (wdf_pop)  wdf_rptr_r <= wdf_rptr_r + wptr_w_lp'(1);
      cmd_cnt_r <= cmd_cnt_n;
      wdf_cnt_r <= wdf_cnt_n;
      if (!calib_r) cal_cnt_r <= cal_cnt_r + cal_w_lp'(1);
      calib_r       <= calib_n;
      error_r       <= error_n;
      app_rdy_o     <= calib_n & (cmd_cnt_n != ccnt_w_lp'(cmd_fifo_els_p));
      app_wdf_rdy_o <= calib_n & (wdf_cnt_n != wcnt_w_lp'(wdf_fifo_els_p));
    end
  end

  // Queue storage needs no reset; pointers define validity.
  always_ff @(posedge clk_i) begin
    if (cmd_push) begin
      cmd_q_r[cmd_wptr_r] <= app_cmd_i;
      idx_q_r[cmd_wptr_r] <= app_idx;
    end
    if (wdf_push) begin
      wdf_data_q_r[wdf_wptr_r] <= app_wdf_data_i;
      wdf_mask_q_r[wdf_wptr_r] <= app_wdf_mask_i;
    end
  end

  // Byte-masked write; a set mask bit protects that byte.
  always_ff @(posedge clk_i) begin
    if (wdf_pop) begin
      for (int unsigned b = 0; b < byte_lp; b++) begin
        if (!wdf_mask_q_r[wdf_rptr_r][b])
          mem_r[head_idx][b*8 +: 8] <= wdf_data_q_r[wdf_rptr_r][b*8 +: 8];
      end
    end
  end

  // Fixed-latency read return pipeline.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rv_r <= '0;
      for (int unsigned i = 0; i < read_latency_p; i++) rd_r[i] <= '0;
    end else begin
      rv_r[0] <= rd_fire;
      rd_r[0] <= rd_fire ? rd_word : '0;
      for (int unsigned i = 1; i < read_latency_p; i++) begin
        rv_r[i] <= rv_r[i-1];
        rd_r[i] <= rd_r[i-1];
      end
    end
  end

  assign app_rd_data_valid_o   = rv_r[read_latency_p-1];
  assign app_rd_data_end_o     = rv_r[read_latency_p-1];
  assign app_rd_data_o         = rd_r[read_latency_p-1];
  assign init_calib_complete_o = calib_r;
  assign error_o               = error_r;

endmodule

// File: tb/tb_bp_xui_mem_responder.sv
// Directed bench for bp_xui_mem_responder: calibration, masked/data-first writes,
// read latency, queue backpressure, address wrap, illegal commands and mid-flight reset.
module tb_bp_xui_mem_responder;

  localparam int unsigned DW = 512;
  localparam int unsigned AW = 28;
  localparam int unsigned MW = DW / 8;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic [AW-1:0] app_addr_i;
  logic [2:0]    app_cmd_i;
  logic          app_en_i;
  logic          app_rdy_o;
  logic          app_wdf_wren_i;
  logic [DW-1:0] app_wdf_data_i;
  logic [MW-1:0] app_wdf_mask_i;
  logic          app_wdf_end_i;
  logic          app_wdf_rdy_o;
  logic          app_rd_data_valid_o;
  logic [DW-1:0] app_rd_data_o;
  logic          app_rd_data_end_o;
  logic          init_calib_complete_o;
  logic          error_o;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] rq[$];
  logic [DW-1:0] got_w;
  logic [DW-1:0] exp_w;
  logic [7:0]    fill_b;
  logic [MW-1:0] mask_b0;

  always #5 clk_i = ~clk_i;

  bp_xui_mem_responder dut (
    .clk_i                 (clk_i),
    .reset_n_i             (reset_n_i),
    .app_addr_i            (app_addr_i),
    .app_cmd_i             (app_cmd_i),
    .app_en_i              (app_en_i),
    .app_rdy_o             (app_rdy_o),
    .app_wdf_wren_i        (app_wdf_wren_i),
    .app_wdf_data_i        (app_wdf_data_i),
    .app_wdf_mask_i        (app_wdf_mask_i),
    .app_wdf_end_i         (app_wdf_end_i),
    .app_wdf_rdy_o         (app_wdf_rdy_o),
    .app_rd_data_valid_o   (app_rd_data_valid_o),
    .app_rd_data_o         (app_rd_data_o),
    .app_rd_data_end_o     (app_rd_data_end_o),
    .init_calib_complete_o (init_calib_complete_o),
    .error_o               (error_o)
  );

  always @(negedge clk_i) begin
    if (app_rd_data_valid_o) rq.push_back(app_rd_data_o);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_cmd(input logic [2:0] c, input logic [AW-1:0] a);
    logic acc;
    int   t;
    acc        = 1'b0;
    t          = 0;
    app_en_i   = 1'b1;
    app_cmd_i  = c;
    app_addr_i = a;
    while (!acc && t < 200) begin
      acc = app_rdy_o;
      @(negedge clk_i);
      t++;
    end
    app_en_i = 1'b0;
    check("cmd_accept", DW'(acc), DW'(1));
  endtask

  task automatic send_wdf(input logic [DW-1:0] d, input logic [MW-1:0] m, input logic e);
    logic acc;
    int   t;
    acc            = 1'b0;
    t              = 0;
    app_wdf_wren_i = 1'b1;
    app_wdf_data_i = d;
    app_wdf_mask_i = m;
    app_wdf_end_i  = e;
    while (!acc && t < 200) begin
      acc = app_wdf_rdy_o;
      @(negedge clk_i);
      t++;
    end
    app_wdf_wren_i = 1'b0;
    app_wdf_end_i  = 1'b0;
    check("wdf_accept", DW'(acc), DW'(1));
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    fork
      send_cmd(3'b000, a);
      send_wdf(d, '0, 1'b1);
    join
    idle(2);
  endtask

  // Read with an empty queue: the pop happens in the cycle right after acceptance.
  task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    send_cmd(3'b001, a);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_i);
      check({tag, "_lat"}, DW'(app_rd_data_valid_o), DW'(k == 4));
    end
    check({tag, "_data"}, app_rd_data_o, exp);
    check({tag, "_end"}, DW'(app_rd_data_end_o), DW'(1));
    @(negedge clk_i);
    check({tag, "_drop"}, DW'(app_rd_data_valid_o), DW'(0));
  endtask

  initial begin
    reset_n_i      = 1'b0;
    app_addr_i     = '0;
    app_cmd_i      = '0;
    app_en_i       = 1'b0;
    app_wdf_wren_i = 1'b0;
    app_wdf_data_i = '0;
    app_wdf_mask_i = '0;
    app_wdf_end_i  = 1'b0;
    mask_b0        = {{(MW-1){1'b1}}, 1'b0};

    idle(3);
    check("rst_outs", DW'({app_rdy_o, app_wdf_rdy_o, init_calib_complete_o,
                           app_rd_data_valid_o, app_rd_data_end_o, error_o}), DW'(0));
    check("rst_rdata", app_rd_data_o, '0);
    reset_n_i = 1'b1;

    // Calibration: low for 15 edges after release, all three high after edge 16.
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk_i);
      check("calib", DW'({init_calib_complete_o, app_rdy_o, app_wdf_rdy_o}),
            (i == 16) ? DW'(3'b111) : DW'(3'b000));
    end

    write_word(AW'(28'h40), {64{8'hA5}});
    read_check("rd40", AW'(28'h40), {64{8'hA5}});

    // Data-first masked write: only byte 0 changes.
    write_word(AW'(28'h80), {64{8'h3C}});
    send_wdf({64{8'h77}}, mask_b0, 1'b1);
    idle(3);
    send_cmd(3'b000, AW'(28'h80));
    idle(2);
    read_check("mask80", AW'(28'h80), {{63{8'h3C}}, 8'h77});

    // Backpressure: a data-less write blocks the head while reads pile up.
    for (int i = 0; i < 5; i++) begin
      fill_b = 8'h10 + 8'(i);
      write_word(AW'((8 + i) * 64), {64{fill_b}});
    end
    idle(2);
    rq.delete();
    send_cmd(3'b000, AW'(20 * 64));
    send_cmd(3'b001, AW'(8 * 64));
    send_cmd(3'b001, AW'(9 * 64));
    send_cmd(3'b001, AW'(10 * 64));
    check("full_rdy", DW'(app_rdy_o), DW'(0));
    fork
      send_cmd(3'b001, AW'(11 * 64));
      begin
        idle(2);
        send_wdf({64{8'hEE}}, '0, 1'b1);
      end
    join
    send_cmd(3'b001, AW'(12 * 64));
    idle(10);
    check("burst_cnt", DW'(rq.size()), DW'(5));
    for (int i = 0; i < 5; i++) begin
      fill_b = 8'h10 + 8'(i);
      exp_w  = {64{fill_b}};
      got_w  = (rq.size() != 0) ? rq.pop_front() : '0;
      check("burst_data", got_w, exp_w);
    end

    // Address wrap: 0x1000 aliases word 0.
    write_word(AW'(28'h0), {64{8'h11}});
    write_word(AW'(28'h1000), {64{8'h22}});
    read_check("wrap", AW'(28'h0), {64{8'h22}});

    // Illegal command sets a sticky error; later reads still work.
    check("err_clean", DW'(error_o), DW'(0));
    send_cmd(3'b010, AW'(28'h40));
    idle(2);
    check("err_set", DW'(error_o), DW'(1));
    read_check("post_err", AW'(28'h40), {64{8'hA5}});
    check("err_sticky", DW'(error_o), DW'(1));

    // Reset with two reads in flight: nothing comes back.
    idle(2);
    rq.delete();
    send_cmd(3'b001, AW'(28'h40));
    send_cmd(3'b001, AW'(28'h80));
    reset_n_i = 1'b0;
    idle(1);
    check("mrst_outs", DW'({error_o, app_rd_data_valid_o, app_rdy_o, init_calib_complete_o}), DW'(0));
    idle(1);
    reset_n_i = 1'b1;
    idle(10);
    check("mrst_novalid", DW'(rq.size()), DW'(0));
    check("mrst_calib_lo", DW'(init_calib_complete_o), DW'(0));
    idle(8);
    check("mrst_calib_hi", DW'(init_calib_complete_o), DW'(1));

    // Write beat without end while ready flags an error but is accepted.
    send_wdf({64{8'h5A}}, '0, 1'b0);
    idle(1);
    check("wdf_end_err", DW'(error_o), DW'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
